// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one unified memory port between instruction fetch and the
//   load/store unit. One access is in flight at a time. Fetch has a
//   starvation bound against the LSU. Load data is sign/zero extended.
//   The memory has no byte enables, so sub-word stores are done as a
//   read followed by a merged full-word write.
//
// Ports
//   clk, rst_b        clock, asynchronous active-low reset
//   halt_req          blocks new grants; an in-flight access still completes
//   if_req/if_addr    fetch request          -> if_gnt, if_rvalid, if_rdata
//   ls_req/ls_we/ls_size/ls_unsigned/ls_addr/ls_wdata
//                     LSU request            -> ls_gnt, ls_rvalid, ls_rdata,
//                                               ls_wdone, ls_err
//   mem_addr, mem_data_in, mem_write_en, mem_data_out
//                     memory pins (word addressed, 4 byte lanes)
//   busy              state is not IDLE
//   dbg_state         current FSM state, for observation only
//
// Handshake: a requester raises req with its payload and holds both stable
// until the matching gnt is seen high in the same cycle. gnt is only
// issued from IDLE while halt_req is low. Responses (rvalid / wdone) are
// one-cycle pulses with no back-pressure. ls_err replaces the access and
// pulses together with ls_gnt.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        halt_req,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic        ls_unsigned,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        ls_wdone,
    output logic        ls_err,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_data_in [0:3],
    input  logic [7:0]  mem_data_out [0:3],
    output logic        mem_write_en,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 2);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_RESP = 2'd1,
        RMW_MERGE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] starve_cnt;

    // Request payload captured at grant time.
    logic [29:0]   cap_waddr;
    logic [1:0]    cap_off;
    logic [1:0]    cap_size;
    logic          cap_unsigned;
    logic [15:0]   cap_wdata;
    logic          cap_is_ls;

    logic          can_grant;
    logic          fetch_wins;
    logic          grant_if;
    logic          grant_ls;
    logic          ls_bad;
    logic          ls_word_store;

    logic [7:0]    merged [0:3];
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   read_word;

    // if_addr[1:0] are ignored: fetch is always a full word.
    logic unused_if_low;
    assign unused_if_low = ^if_addr[1:0];

    // Gating with rst_b keeps every combinational output (notably
    // mem_write_en for a word store) at 0 the moment reset asserts.
    assign can_grant  = rst_b && (state == IDLE) && !halt_req;
    assign fetch_wins = if_req && (!ls_req || (starve_cnt == LIMIT));
    assign grant_if   = can_grant && fetch_wins;
    assign grant_ls   = can_grant && ls_req && !fetch_wins;

    assign ls_bad = (ls_size == 2'd3)
                 || ((ls_size == 2'd1) && ls_addr[0])
                 || ((ls_size == 2'd2) && (ls_addr[1:0] != 2'b00));

    assign ls_word_store = ls_we && (ls_size == 2'd2);

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Read-side lane selection and store merge, both from the word that
    // the memory returns one cycle after the address was presented.
    assign read_word = {mem_data_out[3], mem_data_out[2],
                        mem_data_out[1], mem_data_out[0]};
    assign byte_sel  = mem_data_out[cap_off];
    assign half_sel  = {mem_data_out[{cap_off[1], 1'b1}],
                        mem_data_out[{cap_off[1], 1'b0}]};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            merged[i] = mem_data_out[i];
        end
        if (cap_size == 2'd0) begin
            merged[cap_off] = cap_wdata[7:0];
        end else begin
            merged[{cap_off[1], 1'b0}] = cap_wdata[7:0];
            merged[{cap_off[1], 1'b1}] = cap_wdata[15:8];
        end
    end

    always_comb begin
        if_gnt       = 1'b0;
        if_rvalid    = 1'b0;
        if_rdata     = '0;
        ls_gnt       = 1'b0;
        ls_rvalid    = 1'b0;
        ls_rdata     = '0;
        ls_wdone     = 1'b0;
        ls_err       = 1'b0;
        mem_addr     = '0;
        mem_write_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_data_in[i] = '0;
        end

        if (grant_if) begin
            if_gnt   = 1'b1;
            mem_addr = {if_addr[31:2], 2'b00};
        end

        if (grant_ls) begin
            ls_gnt = 1'b1;
            if (ls_bad) begin
                // Error grants never touch the memory.
                ls_err = 1'b1;
            end else begin
                mem_addr = {ls_addr[31:2], 2'b00};
                if (ls_word_store) begin
                    mem_write_en = 1'b1;
                    ls_wdone     = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        mem_data_in[i] = ls_wdata[8*i +: 8];
                    end
                end
            end
        end

        if (state == READ_RESP) begin
            if (cap_is_ls) begin
                ls_rvalid = 1'b1;
                case (cap_size)
                    2'd0:    ls_rdata = cap_unsigned ? {24'h0, byte_sel}
                                                     : {{24{byte_sel[7]}}, byte_sel};
                    2'd1:    ls_rdata = cap_unsigned ? {16'h0, half_sel}
                                                     : {{16{half_sel[15]}}, half_sel};
                    default: ls_rdata = read_word;
                endcase
            end else begin
                if_rvalid = 1'b1;
                if_rdata  = read_word;
            end
        end

        if (state == RMW_MERGE) begin
            mem_addr     = {cap_waddr, 2'b00};
            mem_write_en = 1'b1;
            ls_wdone     = 1'b1;
            for (int i = 0; i < 4; i++) begin
                mem_data_in[i] = merged[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            cap_waddr    <= '0;
            cap_off      <= '0;
            cap_size     <= '0;
            cap_unsigned <= 1'b0;
            cap_wdata    <= '0;
            cap_is_ls    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_if) begin
                        state     <= READ_RESP;
                        cap_is_ls <= 1'b0;
                        cap_waddr <= if_addr[31:2];
                        cap_off   <= 2'b00;
                        cap_size  <= 2'd2;
                    end else if (grant_ls && !ls_bad && !ls_word_store) begin
                        // Loads wait for data; sub-word stores read first.
                        state        <= ls_we ? RMW_MERGE : READ_RESP;
                        cap_is_ls    <= 1'b1;
                        cap_waddr    <= ls_addr[31:2];
                        cap_off      <= ls_addr[1:0];
                        cap_size     <= ls_size;
                        cap_unsigned <= ls_unsigned;
                        cap_wdata    <= ls_wdata[15:0];
                    end
                end
                default: state <= IDLE;
            endcase

            // Counts LSU wins while fetch is waiting; any fetch grant or a
            // cycle with no fetch request restarts the count.
            if (!if_req || grant_if) begin
                starve_cnt <= '0;
            end else if (grant_ls && (starve_cnt != LIMIT)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter. A small behavioural memory
//   sits on the memory pins. Inputs change 1 ns after the rising edge and
//   outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_b;
    logic        halt_req;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic        ls_unsigned;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_wdone;
    logic        ls_err;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data_in [0:3];
    logic [7:0]  mem_data_out [0:3];
    logic        mem_write_en;
    logic        busy;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errs   = 0;
    logic [31:0] exp_q[$];

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .halt_req     (halt_req),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_gnt       (if_gnt),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .ls_req       (ls_req),
        .ls_we        (ls_we),
        .ls_size      (ls_size),
        .ls_unsigned  (ls_unsigned),
        .ls_addr      (ls_addr),
        .ls_wdata     (ls_wdata),
        .ls_gnt       (ls_gnt),
        .ls_rvalid    (ls_rvalid),
        .ls_rdata     (ls_rdata),
        .ls_wdone     (ls_wdone),
        .ls_err       (ls_err),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_write_en (mem_write_en),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errs, n_checks);
        $fatal(1);
    end

    // ---------------- behavioural memory ----------------
    logic [31:0] mem_words [0:1023];
    logic [31:0] rd_word;
    wire unused_tb = ^{mem_addr[31:12], mem_addr[1:0]};

    always @(posedge clk) begin
        if (mem_write_en) begin
            mem_words[mem_addr[11:2]] <= {mem_data_in[3], mem_data_in[2],
                                          mem_data_in[1], mem_data_in[0]};
        end
        rd_word <= mem_words[mem_addr[11:2]];
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mem_data_out[i] = rd_word[8*i +: 8];
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_load(input logic [31:0] w, input int off,
                                             input int size, input bit uns);
        logic [31:0] s;
        s = w >> (8 * off);
        if (size == 0) return uns ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
        if (size == 1) return uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
        return w;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic ls_issue(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output bit got, output logic err, output logic wdone,
                            output logic wen);
        ls_req = 1'b1; ls_we = we; ls_size = size; ls_unsigned = uns;
        ls_addr = addr; ls_wdata = wdata;
        got = 1'b0; err = 1'b0; wdone = 1'b0; wen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ls_gnt) begin
                got = 1'b1; err = ls_err; wdone = ls_wdone; wen = mem_write_en;
            end
            @(posedge clk); #1;
            if (got) break;
        end
        ls_req = 1'b0;
    endtask

    // which: 0 = if_rvalid, 1 = ls_rvalid, 2 = ls_wdone
    task automatic wait_pulse(input int which, output bit seen, output logic [31:0] data);
        seen = 1'b0; data = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (which == 0 && if_rvalid) begin seen = 1'b1; data = if_rdata; end
            if (which == 1 && ls_rvalid) begin seen = 1'b1; data = ls_rdata; end
            if (which == 2 && ls_wdone)  begin seen = 1'b1; end
            @(posedge clk); #1;
            if (seen) break;
        end
    endtask

    task automatic do_load(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                           output bit ok, output logic [31:0] data);
        bit got, seen;
        logic err, wd, wen;
        ls_issue(1'b0, size, uns, addr, 32'h0, got, err, wd, wen);
        wait_pulse(1, seen, data);
        ok = got && !err && seen;
    endtask

    task automatic do_store(input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, output bit ok);
        bit got, seen;
        logic err, wd, wen;
        logic [31:0] dummy;
        ls_issue(1'b1, size, 1'b0, addr, wdata, got, err, wd, wen);
        if (size == 2'd2) begin
            ok = got && !err && wd;
        end else begin
            wait_pulse(2, seen, dummy);
            ok = got && !err && seen;
        end
    endtask

    task automatic poke(input logic [31:0] addr, input logic [31:0] data);
        bit ok;
        do_store(2'd2, addr, data, ok);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        // A word store and a fetch are requested while reset is held.
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h40; ls_wdata = 32'hFFFF_FFFF;
        if_req = 1'b1; if_addr = 32'h80;
        @(negedge clk);
        n_checks++;
        if ({if_gnt, ls_gnt, mem_write_en, ls_wdone, ls_err, ls_rvalid, if_rvalid, busy} !== 8'h00) begin
            n_errs++;
            $display("FAIL reset_ctrl: gnt_if=%0b gnt_ls=%0b we=%0b wdone=%0b err=%0b rv=%0b/%0b busy=%0b, required all 0",
                     if_gnt, ls_gnt, mem_write_en, ls_wdone, ls_err, ls_rvalid, if_rvalid, busy);
        end
        n_checks++;
        if (mem_addr !== 32'h0 || if_rdata !== 32'h0 || ls_rdata !== 32'h0 || dbg_state !== 2'd0) begin
            n_errs++;
            $display("FAIL reset_data: mem_addr=%h if_rdata=%h ls_rdata=%h state=%0d, required 0",
                     mem_addr, if_rdata, ls_rdata, dbg_state);
        end
        n_checks++;
        if ({mem_data_in[3], mem_data_in[2], mem_data_in[1], mem_data_in[0]} !== 32'h0) begin
            n_errs++;
            $display("FAIL reset_lanes: mem_data_in=%h, required 0",
                     {mem_data_in[3], mem_data_in[2], mem_data_in[1], mem_data_in[0]});
        end
        @(posedge clk); #1;
        ls_req = 1'b0; if_req = 1'b0;
        rst_b = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch();
        logic [31:0] words [0:1];
        logic [31:0] addrs [0:1];
        logic [31:0] exp;
        words[0] = 32'h00A0_0093; addrs[0] = 32'h100;
        words[1] = 32'h1234_5678; addrs[1] = 32'h107;   // low bits must be ignored
        poke(32'h100, words[0]);
        poke(32'h104, words[1]);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(words[k]);
            if_req = 1'b1; if_addr = addrs[k];
            @(negedge clk);
            n_checks++;
            if (if_gnt !== 1'b1 || ls_gnt !== 1'b0 || mem_addr !== {addrs[k][31:2], 2'b00}) begin
                n_errs++;
                $display("FAIL fetch_gnt%0d: if_gnt=%0b mem_addr=%h, required 1 and %h",
                         k, if_gnt, mem_addr, {addrs[k][31:2], 2'b00});
            end
            @(posedge clk); #1;
            if_req = 1'b0;
            @(negedge clk);
            exp = exp_q.pop_front();
            n_checks++;
            if (if_rvalid !== 1'b1 || if_rdata !== exp) begin
                n_errs++;
                $display("FAIL fetch_data%0d: rvalid=%0b rdata=%h, required 1 and %h", k, if_rvalid, if_rdata, exp);
            end
            @(posedge clk); #1;
            @(negedge clk);
            n_checks++;
            if (if_rvalid !== 1'b0 || if_rdata !== 32'h0 || busy !== 1'b0) begin
                n_errs++;
                $display("FAIL fetch_idle%0d: rvalid=%0b rdata=%h busy=%0b, required 0", k, if_rvalid, if_rdata, busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_loads();
        logic [1:0]  sz  [0:7];
        logic        un  [0:7];
        logic [31:0] ad  [0:7];
        logic [31:0] ex  [0:7];
        logic [31:0] got_d, exp;
        bit ok;
        poke(32'h200, 32'h80FF_7F01);
        sz[0] = 0; un[0] = 0; ad[0] = 32'h202; ex[0] = 32'hFFFF_FFFF;
        sz[1] = 0; un[1] = 1; ad[1] = 32'h203; ex[1] = 32'h0000_0080;
        sz[2] = 1; un[2] = 0; ad[2] = 32'h202; ex[2] = 32'hFFFF_80FF;
        sz[3] = 0; un[3] = 0; ad[3] = 32'h200; ex[3] = 32'h0000_0001;
        sz[4] = 0; un[4] = 0; ad[4] = 32'h203; ex[4] = 32'hFFFF_FF80;
        sz[5] = 1; un[5] = 1; ad[5] = 32'h200; ex[5] = 32'h0000_7F01;
        sz[6] = 1; un[6] = 1; ad[6] = 32'h202; ex[6] = 32'h0000_80FF;
        sz[7] = 2; un[7] = 0; ad[7] = 32'h200; ex[7] = 32'h80FF_7F01;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(ex[k]);
            do_load(sz[k], un[k], ad[k], ok, got_d);
            exp = exp_q.pop_front();
            n_checks++;
            if (!ok || got_d !== exp) begin
                n_errs++;
                $display("FAIL load%0d size=%0d uns=%0b addr=%h: got %h (ok=%0b), required %h",
                         k, sz[k], un[k], ad[k], got_d, ok, exp);
            end
        end
    endtask

    task automatic test_sb_rmw();
        bit got, ok;
        logic err, wd, wen;
        logic [31:0] got_d, exp;
        poke(32'h300, 32'h1122_3344);
        ls_issue(1'b1, 2'd0, 1'b0, 32'h301, 32'hCDEF_12AB, got, err, wd, wen);
        n_checks++;
        if (!got || err || wd || wen) begin
            n_errs++;
            $display("FAIL sb_grant: gnt=%0b err=%0b wdone=%0b we=%0b, required 1 0 0 0", got, err, wd, wen);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || dbg_state !== 2'd2 || ls_wdone !== 1'b1 || mem_write_en !== 1'b1 || mem_addr !== 32'h300) begin
            n_errs++;
            $display("FAIL sb_merge: busy=%0b state=%0d wdone=%0b we=%0b addr=%h, required 1 2 1 1 00000300",
                     busy, dbg_state, ls_wdone, mem_write_en, mem_addr);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || ls_wdone !== 1'b0) begin
            n_errs++;
            $display("FAIL sb_after: busy=%0b wdone=%0b, required 0 0", busy, ls_wdone);
        end
        @(posedge clk); #1;
        exp_q.push_back(32'h1122_AB44);
        do_load(2'd2, 1'b0, 32'h300, ok, got_d);
        exp = exp_q.pop_front();
        n_checks++;
        if (!ok || got_d !== exp) begin
            n_errs++;
            $display("FAIL sb_readback: got %h, required %h", got_d, exp);
        end
        do_store(2'd1, 32'h302, 32'h5555_BEEF, ok);
        do_store(2'd0, 32'h300, 32'h0000_0077, ok);
        exp_q.push_back(32'hBEEF_AB77);
        do_load(2'd2, 1'b0, 32'h300, ok, got_d);
        exp = exp_q.pop_front();
        n_checks++;
        if (!ok || got_d !== exp) begin
            n_errs++;
            $display("FAIL sh_sb_readback: got %h, required %h", got_d, exp);
        end
    endtask

    task automatic test_word_store();
        bit got, ok;
        logic err, wd, wen;
        logic [31:0] got_d, exp;
        logic [1:0]  esz [0:3];
        logic        ewe [0:3];
        logic [31:0] ead [0:3];
        ls_issue(1'b1, 2'd2, 1'b0, 32'h400, 32'hDEAD_BEEF, got, err, wd, wen);
        n_checks++;
        if (!got || err || !wd || !wen) begin
            n_errs++;
            $display("FAIL sw_grant: gnt=%0b err=%0b wdone=%0b we=%0b, required 1 0 1 1", got, err, wd, wen);
        end
        // Misaligned word store, illegal size, misaligned half load and word load.
        esz[0] = 2'd2; ewe[0] = 1; ead[0] = 32'h402;
        esz[1] = 2'd3; ewe[1] = 1; ead[1] = 32'h400;
        esz[2] = 2'd1; ewe[2] = 0; ead[2] = 32'h401;
        esz[3] = 2'd2; ewe[3] = 0; ead[3] = 32'h401;
        for (int k = 0; k < 4; k++) begin
            ls_issue(ewe[k], esz[k], 1'b0, ead[k], 32'h1234_5678, got, err, wd, wen);
            n_checks++;
            if (!got || !err || wd || wen) begin
                n_errs++;
                $display("FAIL err%0d size=%0d addr=%h: gnt=%0b err=%0b wdone=%0b we=%0b, required 1 1 0 0",
                         k, esz[k], ead[k], got, err, wd, wen);
            end
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || ls_rvalid !== 1'b0 || ls_wdone !== 1'b0) begin
                n_errs++;
                $display("FAIL err%0d_after: busy=%0b rvalid=%0b wdone=%0b, required 0", k, busy, ls_rvalid, ls_wdone);
            end
            @(posedge clk); #1;
        end
        exp_q.push_back(32'hDEAD_BEEF);
        do_load(2'd2, 1'b0, 32'h400, ok, got_d);
        exp = exp_q.pop_front();
        n_checks++;
        if (!ok || got_d !== exp) begin
            n_errs++;
            $display("FAIL sw_readback: got %h, required %h", got_d, exp);
        end
    endtask

    task automatic test_starvation();
        int grants;
        logic [31:0] exp;
        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_unsigned = 1'b0;
        ls_addr = 32'h500; ls_wdata = 32'h0;
        for (int k = 0; k < 15; k++) exp_q.push_back(32'(k % 5 == 4));
        grants = 0;
        for (int c = 0; c < 60 && grants < 15; c++) begin
            @(negedge clk);
            if (if_gnt || ls_gnt) begin
                exp = exp_q.pop_front();
                n_checks++;
                if ((if_gnt && ls_gnt) || {31'b0, if_gnt} !== exp) begin
                    n_errs++;
                    $display("FAIL starve_grant%0d: if_gnt=%0b ls_gnt=%0b, required fetch=%0d",
                             grants, if_gnt, ls_gnt, exp);
                end
                grants++;
            end
            @(posedge clk); #1;
        end
        if_req = 1'b0; ls_req = 1'b0;
        n_checks++;
        if (grants != 15) begin
            n_errs++;
            $display("FAIL starve_count: saw %0d grants, required 15", grants);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_halt();
        bit got, seen;
        logic err, wd, wen;
        logic [31:0] got_d;
        halt_req = 1'b1;
        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h504; ls_wdata = 32'h1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (if_gnt !== 1'b0 || ls_gnt !== 1'b0 || busy !== 1'b0 || mem_write_en !== 1'b0) begin
                n_errs++;
                $display("FAIL halt_cycle%0d: if_gnt=%0b ls_gnt=%0b busy=%0b we=%0b, required 0",
                         c, if_gnt, ls_gnt, busy, mem_write_en);
            end
            @(posedge clk); #1;
        end
        halt_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ls_gnt !== 1'b1 || if_gnt !== 1'b0) begin
            n_errs++;
            $display("FAIL halt_release: ls_gnt=%0b if_gnt=%0b, required 1 0", ls_gnt, if_gnt);
        end
        @(posedge clk); #1;
        ls_req = 1'b0; if_req = 1'b0;
        // In-flight load completes after halt is raised.
        ls_issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, got, err, wd, wen);
        halt_req = 1'b1;
        exp_q.push_back(32'h80FF_7F01);
        wait_pulse(1, seen, got_d);
        n_checks++;
        if (!got || !seen || got_d !== exp_q[0]) begin
            n_errs++;
            $display("FAIL halt_inflight: seen=%0b data=%h, required 1 and %h", seen, got_d, exp_q[0]);
        end
        void'(exp_q.pop_front());
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_errs++;
            $display("FAIL halt_quiesced: busy=%0b, required 0", busy);
        end
        @(posedge clk); #1;
        halt_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit got, ok;
        logic err, wd, wen;
        logic [31:0] got_d, exp;
        poke(32'h600, 32'hA5A5_A5A5);
        ls_issue(1'b1, 2'd0, 1'b0, 32'h600, 32'h0000_003C, got, err, wd, wen);
        // Now in the merge cycle; reset before its closing edge.
        #1 rst_b = 1'b0;
        #1;
        n_checks++;
        if (mem_write_en !== 1'b0 || ls_wdone !== 1'b0 || busy !== 1'b0 || mem_addr !== 32'h0) begin
            n_errs++;
            $display("FAIL rst_mid_outputs: we=%0b wdone=%0b busy=%0b addr=%h, required 0",
                     mem_write_en, ls_wdone, busy, mem_addr);
        end
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(32'hA5A5_A5A5);
        do_load(2'd2, 1'b0, 32'h600, ok, got_d);
        exp = exp_q.pop_front();
        n_checks++;
        if (!ok || got_d !== exp) begin
            n_errs++;
            $display("FAIL rst_mid_mem: got %h, required %h (write must be dropped)", got_d, exp);
        end
    endtask

    task automatic test_random();
        logic [31:0] shadow [0:7];
        logic [31:0] wd, addr, got_d, exp;
        int idx, off, sz;
        bit uns, ok;
        for (int i = 0; i < 8; i++) begin
            shadow[i] = $urandom;
            poke(32'h700 + 32'(4 * i), shadow[i]);
        end
        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, 7);
            sz  = $urandom_range(0, 2);
            off = (sz == 0) ? $urandom_range(0, 3) : ((sz == 1) ? 2 * $urandom_range(0, 1) : 0);
            uns = 1'($urandom_range(0, 1));
            addr = 32'h700 + 32'(4 * idx + off);
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom;
                case (sz)
                    0:       shadow[idx][8*off +: 8]  = wd[7:0];
                    1:       shadow[idx][8*off +: 16] = wd[15:0];
                    default: shadow[idx] = wd;
                endcase
                do_store(2'(sz), addr, wd, ok);
                n_checks++;
                if (!ok) begin
                    n_errs++;
                    $display("FAIL rnd_store%0d size=%0d addr=%h: completion=%0b, required 1", n, sz, addr, ok);
                end
            end else begin
                exp_q.push_back(ref_load(shadow[idx], off, sz, uns));
                do_load(2'(sz), uns, addr, ok, got_d);
                exp = exp_q.pop_front();
                n_checks++;
                if (!ok || got_d !== exp) begin
                    n_errs++;
                    $display("FAIL rnd_load%0d size=%0d uns=%0b addr=%h: got %h (ok=%0b), required %h",
                             n, sz, uns, addr, got_d, ok, exp);
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(shadow[i]);
            do_load(2'd2, 1'b0, 32'h700 + 32'(4 * i), ok, got_d);
            exp = exp_q.pop_front();
            n_checks++;
            if (!ok || got_d !== exp) begin
                n_errs++;
                $display("FAIL rnd_final%0d: got %h, required %h", i, got_d, exp);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_b = 1'b0; halt_req = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_size = '0; ls_unsigned = 1'b0;
        ls_addr = '0; ls_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_fetch();
        test_loads();
        test_sb_rmw();
        test_word_store();
        test_starvation();
        test_halt();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port of the RISC-V core between instruction fetch and the load/store unit. It serialises accesses, enforces a starvation bound on fetch and formats load data with sign or zero extension. The memory has no byte enables, so sub-word stores are built as read-modify-write. It sits between the core's fetch/LSU logic and the memory's `mem_addr`/`mem_data_in`/`mem_data_out`/`mem_write_en` pins.

## Interface
- `STARVE_LIMIT`, default 4: the maximum number of consecutive LSU grants while `if_req` is pending.
- `clk` in 1: clock; all state updates on posedge.
- `rst_b` in 1: reset; asynchronous, active-low.
- `halt_req` in 1: when high, no new grants are issued; in-flight access completes.
- `if_req` in 1: fetch request; held with `if_addr` stable until `if_gnt`.
- `if_addr` in 32: fetch byte address; bits [1:0] are ignored.
- `if_gnt` out 1: fetch accepted this cycle.
- `if_rvalid` out 1: one-cycle pulse; `if_rdata` is valid.
- `if_rdata` out 32: instruction word, little-endian (lane 0 = bits 7:0).
- `ls_req` in 1: LSU request; held with payload stable until `ls_gnt`.
- `ls_we` in 1: 1 = store, 0 = load.
- `ls_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `ls_unsigned` in 1: zero-extend loads when set, otherwise sign-extend.
- `ls_addr` in 32: byte address.
- `ls_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `ls_gnt` out 1: LSU accepted this cycle.
- `ls_rvalid` out 1: load-data pulse.
- `ls_rdata` out 32: extended load result.
- `ls_wdone` out 1: store-committed pulse.
- `ls_err` out 1: misaligned or illegal-size pulse, issued with `ls_gnt`.
- `mem_addr` out 32: word-aligned ([1:0] = 0); the memory samples it at posedge.
- `mem_data_in` out 8×[0:3]: write lanes; lane i = byte offset i.
- `mem_data_out` in 8×[0:3]: read lanes; valid in the cycle after the address is presented.
- `mem_write_en` out 1: at posedge, writes all 4 lanes at `mem_addr`.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **States:** IDLE, READ_RESP, RMW_MERGE.
- **Arbitration:** grants are made only in IDLE with `halt_req` low. The LSU wins unless `starve_cnt == STARVE_LIMIT` and `if_req` is high; in that case fetch wins. If only one requester is active, it wins.
- **Starvation counter `starve_cnt`:** increments on each LSU grant while `if_req` is high. It clears on a fetch grant or whenever `if_req` is low. It saturates at `STARVE_LIMIT`.
- **Grant cycle (combinational in IDLE):**
  - Assert the winner's gnt.
  - Drive `mem_addr = {addr[31:2], 2'b00}`.
  - Capture addr[1:0], size, unsigned and wdata, plus the requester id.
- **LSU errors:** the request is an error if size is 3, or size is 1 with addr[0] = 1, or size is 2 with addr[1:0] ≠ 0. On error, `ls_err` pulses with `ls_gnt`, memory is not accessed and the state stays IDLE. Fetch never errors.
- **Word store:** in the grant cycle, `mem_write_en` = 1, lanes = `ls_wdata` bytes, `ls_wdone` = 1. The state stays IDLE.
- **Loads and fetch:** IDLE → READ_RESP. In READ_RESP, pulse the requester's rvalid and return to IDLE.
  - Fetch: `if_rdata` = `{lane3, lane2, lane1, lane0}`.
  - LSU byte: take lane addr[1:0].
  - LSU half: take lanes {2·addr[1]+1, 2·addr[1]}.
  - Extend to 32 bits per `ls_unsigned`.
- **Sub-word store:** IDLE → RMW_MERGE, with the grant cycle performing a read.
  - In RMW_MERGE, hold `mem_addr` and take lanes from `mem_data_out`.
  - Replace the target lane(s) with `ls_wdata[7:0]` / `[15:8]`.
  - Assert `mem_write_en`, pulse `ls_wdone`, return to IDLE.
- **Idle outputs:** outside active cycles, `mem_addr`, `mem_data_in`, `mem_write_en`, all gnt/valid/done/err outputs and the rdata outputs are 0.
- **`halt_req`:** blocks only new grants. `busy` falling while `halt_req` is high means the port is quiesced.

## Timing
- **Reset (async):** state = IDLE, `starve_cnt` = 0, captured registers = 0, all outputs = 0. `mem_write_en` is forced to 0 immediately.
- **Reset mid-operation:** the access is abandoned with no rvalid or wdone. A pending RMW write is not performed.
- Grant at cycle T:
  - Word store or error: commits at the T edge; next grant possible at T+1.
  - Load, fetch or sub-word store: response or write at T+1; next grant possible at T+2.
- **Simultaneous requests in IDLE:** the LSU is granted unless the starvation bound is hit. The loser sees gnt = 0 and must keep holding its request.
- A requester must not deassert req before gnt; behaviour is undefined otherwise.

## Test plan
- **Fetch only:** memory word at 0x100 = 0x00A00093, `if_req` with `if_addr` 0x100 → `if_gnt` at T, `if_rvalid` at T+1 with `if_rdata` = 0x00A00093.
- **LB sign-extension:** word at 0x200 = 0x80FF7F01; LB at 0x202 (signed) → `ls_rdata` = 0xFFFFFFFF. LBU at 0x203 → 0x00000080. LH at 0x202 → 0xFFFF80FF.
- **SB read-modify-write:** word at 0x300 = 0x11223344; SB at 0x301 with wdata 0xAB → `busy` for 1 cycle, `ls_wdone` at T+1; readback = 0x1122AB44.
- **Word store and misalignment:** SW at 0x400 with wdata 0xDEADBEEF → `ls_wdone` in the grant cycle. SW at 0x402 → `ls_err` = 1 and memory is unchanged.
- **Starvation:** hold `if_req` and `ls_req` continuously with `STARVE_LIMIT` = 4 → 4 LSU grants, then 1 fetch grant, with the pattern repeating.
- **Async reset and halt:** assert `rst_b` = 0 during RMW_MERGE → no write, all outputs 0. With `halt_req` = 1 and both requests pending → no gnt, `busy` = 0.
